// File: rtl/scmp_useq.sv
// ---------------------------------------------------------------------------
// scmp_useq : microcode sequencer for the SC/MP core.
//
// Computes the next microcode address (uPC) from the sequencing field of the
// current microinstruction. Besides flat opcode dispatch it provides a
// micro-subroutine return stack, conditional branches, a loadable delay
// counter for multi-cycle waits and a bus-hold freeze.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   hold       : freeze all sequencer state this cycle (bus wait)
//   mode       : 0 SEQ, 1 JMP, 2 BRT, 3 BRF, 4 DISP, 5 CALL, 6 RET, 7 WAIT
//   target     : branch/call target, fallback address for RET on empty stack
//   cond       : branch condition for BRT/BRF
//   disp_pc    : opcode dispatch entry address
//   dly_load   : load the delay counter from dly_value
//   dly_value  : delay count in cycles
//   upc        : current microcode address (registered)
//   stk_depth  : current return stack occupancy
//   stk_err    : sticky stack overflow/underflow flag
//   dly_busy   : delay counter is nonzero
// ---------------------------------------------------------------------------
module scmp_useq #(
  parameter int               UPC_W       = 8,
  parameter int               STACK_DEPTH = 4,
  parameter int               CNT_W       = 18,
  parameter logic [UPC_W-1:0] RESET_UPC   = '0,
  localparam int              DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [2:0]         mode,
  input  logic [UPC_W-1:0]   target,
  input  logic               cond,
  input  logic [UPC_W-1:0]   disp_pc,
  input  logic               dly_load,
  input  logic [CNT_W-1:0]   dly_value,
  output logic [UPC_W-1:0]   upc,
  output logic [DEPTH_W-1:0] stk_depth,
  output logic               stk_err,
  output logic               dly_busy
);

  localparam logic [2:0] MODE_SEQ  = 3'd0;
  localparam logic [2:0] MODE_JMP  = 3'd1;
  localparam logic [2:0] MODE_BRT  = 3'd2;
  localparam logic [2:0] MODE_BRF  = 3'd3;
  localparam logic [2:0] MODE_DISP = 3'd4;
  localparam logic [2:0] MODE_CALL = 3'd5;
  localparam logic [2:0] MODE_RET  = 3'd6;
  localparam logic [2:0] MODE_WAIT = 3'd7;

  // The stack array is sized to the full range of the depth register so it
  // can be indexed directly by depth without a narrowing slice; entries at
  // and above STACK_DEPTH are never written.
  localparam int STK_N = 1 << DEPTH_W;

  logic [UPC_W-1:0]   upc_q, upc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [UPC_W-1:0]   stack_q [STK_N];

  logic [UPC_W-1:0]   inc;
  logic [DEPTH_W-1:0] pop_idx;
  logic               stk_full;
  logic               stk_empty;
  logic               push_en;

  assign inc       = upc_q + UPC_W'(1);
  assign pop_idx   = depth_q - DEPTH_W'(1);
  assign stk_full  = (depth_q >= DEPTH_W'(STACK_DEPTH));
  assign stk_empty = (depth_q == '0);

  // Next-state logic. Every register defaults to holding its value, which
  // also covers the hold=1 freeze. The delay counter is loaded by dly_load
  // in any mode; only WAIT counts it down, and the upc stays put while the
  // counter is nonzero or being loaded.
  always_comb begin
    upc_d   = upc_q;
    depth_d = depth_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    push_en = 1'b0;

    if (!hold) begin
      if (dly_load) begin
        cnt_d = dly_value;
      end

      case (mode)
        MODE_SEQ:  upc_d = inc;
        MODE_JMP:  upc_d = target;
        MODE_BRT:  upc_d = cond ? target : inc;
        MODE_BRF:  upc_d = cond ? inc : target;
        MODE_DISP: upc_d = disp_pc;
        MODE_CALL: begin
          upc_d = target;
          if (stk_full) begin
            err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
          end
        end
        MODE_RET: begin
          if (stk_empty) begin
            upc_d = target;
            err_d = 1'b1;
          end else begin
            upc_d   = stack_q[pop_idx];
            depth_d = pop_idx;
          end
        end
        MODE_WAIT: begin
          if (!dly_load) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              upc_d = inc;
            end
          end
        end
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  // Sequencer state registers; busy is registered alongside the counter so
  // that every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upc_q   <= RESET_UPC;
      depth_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      upc_q   <= upc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Return stack storage. Contents are don't-care after reset because the
  // depth register alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[depth_q] <= inc;
    end
  end

  assign upc       = upc_q;
  assign stk_depth = depth_q;
  assign stk_err   = err_q;
  assign dly_busy  = busy_q;

endmodule
